ps2_scancode_parser: RTL and testbench

Consumes the byte stream from PS2_Controller (received_data / received_data_en) and turns PS/2 Set-2 scan-code sequences into single key events. It resolves the E0, F0 and E1 prefixes and tracks modifier and caps-lock state. Keyboard status bytes are reported on a separate channel. Events drive the write side of the Keyboard_Buffer instances; modifier bits go into the upper bits of the raw buffer word.

---
 rtl/ps2_pkg.sv | 66 ++++++
 rtl/ps2_scancode_parser.sv | 189 ++++++++++++++++++
 tb/tb_ps2_scancode_parser.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 Set-2 scan-code parser.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StE0,
    StF0,
    StE0F0,
    StPause
  } state_e;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  localparam logic [7:0] ST_BAT_OK   = 8'hAA;
  localparam logic [7:0] ST_ACK      = 8'hFA;
  localparam logic [7:0] ST_ECHO     = 8'hEE;
  localparam logic [7:0] ST_BAT_FAIL = 8'hFC;
  localparam logic [7:0] ST_DIAG_ERR = 8'hFD;
  localparam logic [7:0] ST_RESEND   = 8'hFE;
  localparam logic [7:0] ST_OVF_LO   = 8'h00;
  localparam logic [7:0] ST_OVF_HI   = 8'hFF;

  // Print Screen wraps itself in fake shift codes that must be dropped.
  localparam logic [7:0] FAKE_LSHFT = 8'h12;
  localparam logic [7:0] FAKE_RSHFT = 8'h59;

  // Bytes after E1 for Pause; entry 0 is the first one expected.
  localparam logic [6:0][7:0] PAUSE_SEQ = {8'h77, 8'hF0, 8'h14, 8'hF0, 8'hE1, 8'h77, 8'h14};

  localparam int unsigned MOD_LCTRL = 8;
  localparam int unsigned MOD_LSHFT = 7;
  localparam int unsigned MOD_LALT  = 6;
  localparam int unsigned MOD_LWIN  = 5;
  localparam int unsigned MOD_RCTRL = 4;
  localparam int unsigned MOD_RSHFT = 3;
  localparam int unsigned MOD_RALT  = 2;
  localparam int unsigned MOD_RWIN  = 1;
  localparam int unsigned MOD_CAPS  = 0;

  localparam logic [8:0] KEY_LSHFT = 9'h012;
  localparam logic [8:0] KEY_RSHFT = 9'h059;
  localparam logic [8:0] KEY_LCTRL = 9'h014;
  localparam logic [8:0] KEY_RCTRL = 9'h114;
  localparam logic [8:0] KEY_LALT  = 9'h011;
  localparam logic [8:0] KEY_RALT  = 9'h111;
  localparam logic [8:0] KEY_LWIN  = 9'h11F;
  localparam logic [8:0] KEY_RWIN  = 9'h127;
  localparam logic [8:0] KEY_CAPS  = 9'h058;
  localparam logic [8:0] KEY_PAUSE = 9'h177;

  function automatic logic is_status(input logic [7:0] b);
    return (b == ST_BAT_OK) || (b == ST_ACK) || (b == ST_ECHO) || (b == ST_BAT_FAIL) ||
           (b == ST_DIAG_ERR) || (b == ST_RESEND) || (b == ST_OVF_LO) || (b == ST_OVF_HI);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PFX_E0) || (b == PFX_F0) || (b == PFX_E1);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == FAKE_LSHFT) || (b == FAKE_RSHFT);
  endfunction

endpackage

// File: rtl/ps2_scancode_parser.sv
// Turns the PS/2 byte stream into key events with modifier/caps tracking, and
// forwards keyboard status bytes on their own strobe.
module ps2_scancode_parser
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       key_valid,
  output logic [8:0] key_code,
  output logic       key_make,
  output logic       key_repeat,
  output logic [8:0] modifiers,
  output logic       status_valid,
  output logic [7:0] status_code,
  output logic       seq_error
);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_set, ev, ev_make, ev_pause, st_ev, reparse, rep;
  logic [8:0]       ev_code, mods_d, last_d;

  logic       key_valid_q, key_make_q, key_repeat_q, status_valid_q, seq_err_q;
  logic [8:0] key_code_q, mods_q, last_make_q;
  logic [7:0] status_code_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_set  = 1'b0;
    ev       = 1'b0;
    ev_code  = '0;
    ev_make  = 1'b0;
    ev_pause = 1'b0;
    st_ev    = 1'b0;
    reparse  = 1'b0;
    if (received_data_en) begin
      cnt_d = '0;
      case (state_q)
        StIdle: reparse = 1'b1;
        StE0: begin
          state_d = StIdle;
          if (received_data == PFX_F0) begin
            state_d = StE0F0;
          end else if (!is_fake_shift(received_data)) begin
            ev      = 1'b1;
            ev_code = {1'b1, received_data};
            ev_make = 1'b1;
          end
        end
        StF0: begin
          state_d = StIdle;
          if (is_prefix(received_data)) begin
            err_set = 1'b1;
          end else begin
            ev      = 1'b1;
            ev_code = {1'b0, received_data};
          end
        end
        StE0F0: begin
          state_d = StIdle;
          if (is_prefix(received_data)) begin
            err_set = 1'b1;
          end else if (!is_fake_shift(received_data)) begin
            ev      = 1'b1;
            ev_code = {1'b1, received_data};
          end
        end
        StPause: begin
          if (received_data == PAUSE_SEQ[idx_q]) begin
            if (idx_q == 3'd6) begin
              state_d  = StIdle;
              idx_d    = '0;
              ev       = 1'b1;
              ev_code  = KEY_PAUSE;
              ev_make  = 1'b1;
              ev_pause = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            // A broken Pause sequence still lets the offending byte start something new.
            err_set = 1'b1;
            reparse = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
      if (reparse) begin
        state_d = StIdle;
        idx_d   = '0;
        if (received_data == PFX_E0) begin
          state_d = StE0;
        end else if (received_data == PFX_F0) begin
          state_d = StF0;
        end else if (received_data == PFX_E1) begin
          state_d = StPause;
        end else if (is_status(received_data)) begin
          st_ev = 1'b1;
        end else begin
          ev      = 1'b1;
          ev_code = {1'b0, received_data};
          ev_make = 1'b1;
        end
      end
    end else if (state_q != StIdle) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = StIdle;
        idx_d   = '0;
        cnt_d   = '0;
        err_set = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rep    = ev_make && !ev_pause && (ev_code == last_make_q);
    mods_d = mods_q;
    last_d = last_make_q;
    case (ev_code)
      KEY_LCTRL: mods_d[MOD_LCTRL] = ev_make;
      KEY_LSHFT: mods_d[MOD_LSHFT] = ev_make;
      KEY_LALT:  mods_d[MOD_LALT]  = ev_make;
      KEY_LWIN:  mods_d[MOD_LWIN]  = ev_make;
      KEY_RCTRL: mods_d[MOD_RCTRL] = ev_make;
      KEY_RSHFT: mods_d[MOD_RSHFT] = ev_make;
      KEY_RALT:  mods_d[MOD_RALT]  = ev_make;
      KEY_RWIN:  mods_d[MOD_RWIN]  = ev_make;
      KEY_CAPS:  if (ev_make && !rep) mods_d[MOD_CAPS] = ~mods_q[MOD_CAPS];
      default: ;
    endcase
    if (ev_make) begin
      last_d = ev_code;
    end else if (ev_code == last_make_q) begin
      last_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      cnt_q          <= '0;
      key_valid_q    <= 1'b0;
      key_code_q     <= '0;
      key_make_q     <= 1'b0;
      key_repeat_q   <= 1'b0;
      mods_q         <= '0;
      last_make_q    <= '0;
      status_valid_q <= 1'b0;
      status_code_q  <= '0;
      seq_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      key_valid_q    <= ev;
      status_valid_q <= st_ev;
      if (err_set) seq_err_q <= 1'b1;
      if (ev) begin
        key_code_q   <= ev_code;
        key_make_q   <= ev_make;
        key_repeat_q <= rep;
        mods_q       <= mods_d;
        last_make_q  <= last_d;
      end
      if (st_ev) status_code_q <= received_data;
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_make     = key_make_q;
  assign key_repeat   = key_repeat_q;
  assign modifiers    = mods_q;
  assign status_valid = status_valid_q;
  assign status_code  = status_code_q;
  assign seq_error    = seq_err_q;

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Directed vector table, corner-case sequences and a randomized byte stream
// checked against a pattern-matching reference model.
module tb_ps2_scancode_parser;

  localparam int unsigned T = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rd  = '0;
  logic       en  = 1'b0;
  logic       key_valid, key_make, key_repeat, status_valid, seq_error;
  logic [8:0] key_code, modifiers;
  logic [7:0] status_code;

  ps2_scancode_parser #(.TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50        (clk),
    .reset           (rst),
    .received_data   (rd),
    .received_data_en(en),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .key_make        (key_make),
    .key_repeat      (key_repeat),
    .modifiers       (modifiers),
    .status_valid    (status_valid),
    .status_code     (status_code),
    .seq_error       (seq_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    rd = b;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("idle_key_valid", 32'(key_valid), 32'd0);
      chk("idle_status_valid", 32'(status_valid), 32'd0);
    end
  endtask

  // Reference model: accumulates the pending sequence and matches it whole.
  logic [7:0] m_buf[$];
  logic [7:0] pause_ref[7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [8:0] m_code, m_mods, m_last;
  logic       m_make, m_rep, m_err;
  logic [7:0] m_sc;
  bit         e_kv, e_sv;

  task automatic model_reset();
    m_buf.delete();
    m_code = '0; m_mods = '0; m_last = '0;
    m_make = 1'b0; m_rep = 1'b0; m_err = 1'b0; m_sc = '0;
  endtask

  function automatic int mod_idx(input logic [8:0] c);
    case (c)
      9'h014: return 8;
      9'h012: return 7;
      9'h011: return 6;
      9'h11F: return 5;
      9'h114: return 4;
      9'h059: return 3;
      9'h111: return 2;
      9'h127: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic bit m_status(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic m_key(input logic [8:0] c, input bit mk, input bit pause);
    int mi;
    bit rp;
    rp = mk && !pause && (c == m_last);
    mi = mod_idx(c);
    if (mi >= 0) m_mods[mi] = mk;
    else if (c == 9'h058 && mk && !rp) m_mods[0] = ~m_mods[0];
    if (mk) m_last = c;
    else if (c == m_last) m_last = '0;
    m_code = c; m_make = mk; m_rep = rp; e_kv = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit again;
    int n;
    logic [7:0] x;
    e_kv = 1'b0;
    e_sv = 1'b0;
    m_buf.push_back(b);
    do begin
      again = 1'b0;
      n = m_buf.size();
      x = m_buf[n-1];
      if (m_buf[0] == 8'hE1) begin
        if (n > 1) begin
          if (x != pause_ref[n-2]) begin
            m_err = 1'b1;
            m_buf.delete();
            m_buf.push_back(b);
            again = 1'b1;
          end else if (n == 8) begin
            m_key(9'h177, 1'b1, 1'b1);
            m_buf.delete();
          end
        end
      end else if (n == 1) begin
        if (x != 8'hE0 && x != 8'hF0) begin
          if (m_status(x)) begin
            e_sv = 1'b1;
            m_sc = x;
          end else begin
            m_key({1'b0, x}, 1'b1, 1'b0);
          end
          m_buf.delete();
        end
      end else if (n == 2 && m_buf[0] == 8'hE0) begin
        if (x != 8'hF0) begin
          if (x != 8'h12 && x != 8'h59) m_key({1'b1, x}, 1'b1, 1'b0);
          m_buf.delete();
        end
      end else if (n == 2) begin
        if (x inside {8'hE0, 8'hF0, 8'hE1}) m_err = 1'b1;
        else m_key({1'b0, x}, 1'b0, 1'b0);
        m_buf.delete();
      end else begin
        if (x inside {8'hE0, 8'hF0, 8'hE1}) m_err = 1'b1;
        else if (x != 8'h12 && x != 8'h59) m_key({1'b1, x}, 1'b0, 1'b0);
        m_buf.delete();
      end
    end while (again);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_key_valid"}, 32'(key_valid), 32'(e_kv));
    chk({tag, "_status_valid"}, 32'(status_valid), 32'(e_sv));
    chk({tag, "_seq_error"}, 32'(seq_error), 32'(m_err));
    chk({tag, "_key_code"}, 32'(key_code), 32'(m_code));
    chk({tag, "_key_make"}, 32'(key_make), 32'(m_make));
    chk({tag, "_key_repeat"}, 32'(key_repeat), 32'(m_rep));
    chk({tag, "_modifiers"}, 32'(modifiers), 32'(m_mods));
    chk({tag, "_status_code"}, 32'(status_code), 32'(m_sc));
  endtask

  task automatic send_m(input logic [7:0] b, input string tag);
    drive(b);
    model_byte(b);
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] d;
    bit         kv;
    logic [8:0] code;
    bit         mk;
    bit         rp;
    logic [8:0] mods;
    bit         sv;
    logic [7:0] sc;
    bit         err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [7:0] d, input bit kv, input logic [8:0] code,
                              input bit mk, input bit rp, input logic [8:0] mods, input bit err);
    tbl.push_back('{d, kv, code, mk, rp, mods, 1'b0, 8'h00, err});
  endfunction

  function automatic void add0(input logic [7:0] d, input bit err);
    tbl.push_back('{d, 1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 1'b0, 8'h00, err});
  endfunction

  logic [7:0] keys[9]   = '{8'h1C, 8'h1B, 8'h23, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h2B};
  logic [7:0] ext[7]    = '{8'h14, 8'h11, 8'h1F, 8'h27, 8'h7C, 8'h75, 8'h12};
  logic [7:0] stats[8]  = '{8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD, 8'hFE, 8'h00, 8'hFF};
  logic [7:0] pfx[3]    = '{8'hE0, 8'hF0, 8'hE1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq[$];
    logic [7:0] lk;
    model_reset();
    #1;
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_modifiers", 32'(modifiers), 32'd0);
    chk("rst_seq_error", 32'(seq_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    add(8'h1C, 1, 9'h01C, 1, 0, 9'h000, 0);
    add0(8'hF0, 0);
    add(8'h1C, 1, 9'h01C, 0, 0, 9'h000, 0);
    add(8'h12, 1, 9'h012, 1, 0, 9'h080, 0);
    add(8'h12, 1, 9'h012, 1, 1, 9'h080, 0);
    add(8'h1C, 1, 9'h01C, 1, 0, 9'h080, 0);
    add0(8'hF0, 0);
    add(8'h12, 1, 9'h012, 0, 0, 9'h000, 0);
    add0(8'hE0, 0); add0(8'h12, 0);
    add0(8'hE0, 0); add(8'h7C, 1, 9'h17C, 1, 0, 9'h000, 0);
    add0(8'hE0, 0); add0(8'hF0, 0); add(8'h7C, 1, 9'h17C, 0, 0, 9'h000, 0);
    add0(8'hE0, 0); add0(8'hF0, 0); add0(8'h12, 0);
    add(8'h58, 1, 9'h058, 1, 0, 9'h001, 0);
    add0(8'hF0, 0);
    add(8'h58, 1, 9'h058, 0, 0, 9'h001, 0);
    add(8'h58, 1, 9'h058, 1, 0, 9'h000, 0);
    tbl.push_back('{8'hAA, 1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 1'b1, 8'hAA, 1'b0});
    add0(8'hE1, 0); add0(8'h14, 0); add0(8'h77, 0); add0(8'hE1, 0);
    add0(8'hF0, 0); add0(8'h14, 0); add0(8'hF0, 0);
    add(8'h77, 1, 9'h177, 1, 0, 9'h000, 0);
    add0(8'hE1, 0); add0(8'h14, 0);
    add(8'h1C, 1, 9'h01C, 1, 0, 9'h000, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].d);
      chk($sformatf("tbl%0d_key_valid", i), 32'(key_valid), 32'(tbl[i].kv));
      chk($sformatf("tbl%0d_status_valid", i), 32'(status_valid), 32'(tbl[i].sv));
      chk($sformatf("tbl%0d_seq_error", i), 32'(seq_error), 32'(tbl[i].err));
      if (tbl[i].kv) begin
        chk($sformatf("tbl%0d_key_code", i), 32'(key_code), 32'(tbl[i].code));
        chk($sformatf("tbl%0d_key_make", i), 32'(key_make), 32'(tbl[i].mk));
        chk($sformatf("tbl%0d_key_repeat", i), 32'(key_repeat), 32'(tbl[i].rp));
        chk($sformatf("tbl%0d_modifiers", i), 32'(modifiers), 32'(tbl[i].mods));
      end
      if (tbl[i].sv) chk($sformatf("tbl%0d_status_code", i), 32'(status_code), 32'(tbl[i].sc));
      idle(1);
    end

    // Prefix after F0 is illegal and yields no event.
    do_reset();
    send_m(8'hF0, "f0pfx_a");
    send_m(8'hE0, "f0pfx_b");
    chk("f0pfx_err", 32'(seq_error), 32'd1);
    send_m(8'h1C, "f0pfx_c");

    // Timeout abandons the sequence after T byte-free cycles.
    do_reset();
    send_m(8'hE0, "to_a");
    idle(T - 2);
    chk("to_not_yet", 32'(seq_error), 32'd0);
    idle(4);
    chk("to_err", 32'(seq_error), 32'd1);
    m_buf.delete();
    m_err = 1'b1;
    send_m(8'h7C, "to_b");
    chk("to_b_code", 32'(key_code), 32'h07C);

    // A byte on the expiry cycle is still taken by the open sequence.
    do_reset();
    send_m(8'hE0, "exp_a");
    idle(T - 1);
    send_m(8'h7C, "exp_b");
    chk("exp_code", 32'(key_code), 32'h17C);
    chk("exp_err", 32'(seq_error), 32'd0);

    // Asynchronous reset mid-sequence clears outputs without a clock edge.
    do_reset();
    send_m(8'h12, "ar_a");
    send_m(8'hE0, "ar_b");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_key_code", 32'(key_code), 32'd0);
    chk("ar_modifiers", 32'(modifiers), 32'd0);
    chk("ar_key_make", 32'(key_make), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send_m(8'h7C, "ar_c");

    // Randomized stream, back-to-back or with short gaps.
    do_reset();
    lk = 8'h1C;
    for (int s = 0; s < 400; s++) begin
      int r;
      int np;
      seq.delete();
      r = $urandom_range(0, 10);
      case (r)
        0, 1, 2: begin lk = keys[$urandom_range(0, 8)]; seq.push_back(lk); end
        3: begin seq.push_back(8'hF0); seq.push_back(keys[$urandom_range(0, 8)]); end
        4: begin seq.push_back(8'hE0); seq.push_back(ext[$urandom_range(0, 6)]); end
        5: begin
          seq.push_back(8'hE0); seq.push_back(8'hF0); seq.push_back(ext[$urandom_range(0, 6)]);
        end
        6: seq.push_back(stats[$urandom_range(0, 7)]);
        7: begin
          seq.push_back(8'hE1);
          for (int k = 0; k < 7; k++) seq.push_back(pause_ref[k]);
        end
        8: begin
          np = $urandom_range(0, 6);
          seq.push_back(8'hE1);
          for (int k = 0; k < np; k++) seq.push_back(pause_ref[k]);
          seq.push_back(keys[$urandom_range(0, 8)]);
        end
        9: begin seq.push_back(lk); seq.push_back(lk); end
        default: begin seq.push_back(8'hF0); seq.push_back(pfx[$urandom_range(0, 2)]); end
      endcase
      foreach (seq[k]) begin
        send_m(seq[k], $sformatf("rnd%0d_%0d", s, k));
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
